// File: rtl/uart_mmio16_if.sv
// CPU-side word bus for the memory-mapped UART: one access per cycle while cs is high.
interface uart_mmio16_if;
    logic        cs;
    logic        we;
    logic        addr;
    logic [15:0] din;
    logic [15:0] dout;

    modport master (output cs, output we, output addr, output din, input dout);
    modport slave  (input cs, input we, input addr, input din, output dout);
endinterface

// File: rtl/uart_mmio16.sv
// 8N1 UART on the 16-bit bus: status/control word at offset 0, data byte at offset 1.
module uart_mmio16 #(
    parameter int unsigned DIVISOR = 434
) (
    input  logic          clk,
    input  logic          reset,
    uart_mmio16_if.slave  bus,
    input  logic          rxd,
    output logic          txd,
    output logic          irq
);

    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] BIT_TICKS  = TW'(DIVISOR);
    localparam logic [TW-1:0] HALF_TICKS = TW'(DIVISOR / 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          tx_state_q;
    logic [TW-1:0]   tx_tmr_q;
    logic [7:0]      tx_shift_q;
    logic [2:0]      tx_cnt_q;
    logic            txd_q;
    logic            tx_ready_q;

    state_e          rx_state_q;
    logic [TW-1:0]   rx_tmr_q;
    logic [7:0]      rx_shift_q;
    logic [2:0]      rx_cnt_q;
    logic [1:0]      sync_q;
    logic [7:0]      rx_byte_q;
    logic            rx_valid_q;
    logic            ovr_q;
    logic            fe_q;

    logic [15:0]     dout_q;

    // Bus decode; a soft reset behaves like reset for all state except dout.
    logic rd_c, data_rd_c, data_wr_c, soft_rst_c, clr_c, rs_c;
    logic tx_exp_c, rx_exp_c, rx_done_c;
    logic unused_c;

    assign rd_c       = bus.cs & ~bus.we;
    assign data_rd_c  = rd_c & bus.addr;
    assign data_wr_c  = bus.cs & bus.we & bus.addr;
    assign soft_rst_c = bus.cs & bus.we & ~bus.addr & (bus.din[1:0] == 2'b11);
    assign clr_c      = reset | soft_rst_c;
    assign rs_c       = sync_q[1];
    assign tx_exp_c   = (tx_tmr_q == TW'(1));
    assign rx_exp_c   = (rx_tmr_q == TW'(1));
    assign rx_done_c  = (rx_state_q == S_STOP) & rx_exp_c;
    assign unused_c   = ^bus.din[15:8];

    assign bus.dout = dout_q;
    assign txd      = txd_q;
    assign irq      = rx_valid_q;

    // Read data register: loaded on every read, otherwise holds (soft reset leaves it alone).
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else if (rd_c) begin
            dout_q <= bus.addr ? {8'h00, rx_byte_q}
                               : {12'h000, fe_q, ovr_q, tx_ready_q, rx_valid_q};
        end
    end

    // Transmitter FSM: start bit, 8 data bits LSB first, stop bit, each BIT_TICKS cycles.
    always_ff @(posedge clk) begin
        if (clr_c) begin
            tx_state_q <= S_IDLE;
            tx_tmr_q   <= '0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    if (data_wr_c) begin
                        tx_shift_q <= bus.din[7:0];
                        txd_q      <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_tmr_q   <= BIT_TICKS;
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_exp_c) begin
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_cnt_q   <= '0;
                        tx_tmr_q   <= BIT_TICKS;
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_tmr_q <= tx_tmr_q - TW'(1);
                    end
                end
                S_DATA: begin
                    if (tx_exp_c) begin
                        tx_tmr_q <= BIT_TICKS;
                        if (tx_cnt_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= S_STOP;
                        end else begin
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_cnt_q   <= tx_cnt_q + 3'd1;
                        end
                    end else begin
                        tx_tmr_q <= tx_tmr_q - TW'(1);
                    end
                end
                default: begin
                    if (tx_exp_c) begin
                        tx_ready_q <= 1'b1;
                        tx_state_q <= S_IDLE;
                    end else begin
                        tx_tmr_q <= tx_tmr_q - TW'(1);
                    end
                end
            endcase
        end
    end

    // Receiver: 2-flop synchronizer, mid-bit sampling FSM and the rx status flags.
    always_ff @(posedge clk) begin
        if (clr_c) begin
            sync_q     <= 2'b11;
            rx_state_q <= S_IDLE;
            rx_tmr_q   <= '0;
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rxd};

            case (rx_state_q)
                S_IDLE: begin
                    if (!rs_c) begin
                        rx_tmr_q   <= HALF_TICKS;
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (rx_exp_c) begin
                        if (rs_c) begin
                            rx_state_q <= S_IDLE;
                        end else begin
                            rx_cnt_q   <= '0;
                            rx_tmr_q   <= BIT_TICKS;
                            rx_state_q <= S_DATA;
                        end
                    end else begin
                        rx_tmr_q <= rx_tmr_q - TW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_exp_c) begin
                        rx_shift_q <= {rs_c, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_cnt_q + 3'd1;
                        rx_tmr_q   <= BIT_TICKS;
                        if (rx_cnt_q == 3'd7) begin
                            rx_state_q <= S_STOP;
                        end
                    end else begin
                        rx_tmr_q <= rx_tmr_q - TW'(1);
                    end
                end
                default: begin
                    if (rx_exp_c) begin
                        rx_state_q <= S_IDLE;
                    end else begin
                        rx_tmr_q <= rx_tmr_q - TW'(1);
                    end
                end
            endcase

            // A byte landing together with a data read replaces the one being read.
            if (rx_done_c) begin
                if (!rx_valid_q || data_rd_c) begin
                    rx_byte_q  <= rx_shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
                if (!rs_c) begin
                    fe_q <= 1'b1;
                end
            end else if (data_rd_c) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

endmodule
